// File: rtl/uart_mult_byte_tx_if.sv
// Handshake bundle between upstream control logic and the multi-byte UART transmitter.
interface uart_mult_byte_tx_if #(parameter int MAX_BYTES = 11);
  logic                   tx_start;
  logic [7:0]             tx_len;
  logic [MAX_BYTES*8-1:0] tx_data;
  logic                   tx_busy;
  logic                   tx_done;

  modport master (output tx_start, tx_len, tx_data, input tx_busy, tx_done);
  modport slave  (input tx_start, tx_len, tx_data, output tx_busy, tx_done);
endinterface

// File: rtl/uart_mult_byte_tx.sv
// Multi-byte UART frame transmitter: header, clamped length, payload, optional CRC8.
// Define UART_TX_CRC8_EN to append a CRC8 (poly 0x07, init 0) over length and payload.
module uart_mult_byte_tx #(
  parameter int         _CLK_FREQ  = 50_000_000,
  parameter int         _BAUD      = 115200,
  parameter int         _MAX_BYTES = 11,
  parameter logic [7:0] _HEADER    = 8'hA5
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  uart_mult_byte_tx_if.slave bus,
  output logic               uart_txd
);

  localparam int BPS_CNT = _CLK_FREQ / _BAUD;
  localparam int CW      = $clog2(BPS_CNT);
  localparam int IW      = $clog2(_MAX_BYTES + 4);
`ifdef UART_TX_CRC8_EN
  localparam int EXTRA   = 3;
`else
  localparam int EXTRA   = 2;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t                  state;
  logic [CW-1:0]           baud_cnt;
  logic [2:0]              bit_idx;
  logic [IW-1:0]           byte_idx;
  logic [7:0]              len;
  logic [_MAX_BYTES*8-1:0] shadow;
  logic [7:0]              shift;
  logic [7:0]              next_byte;
  logic [IW-1:0]           total;
  logic                    is_payload;
  logic                    baud_end;

  assign total      = IW'(len) + IW'(EXTRA);
  assign baud_end   = (baud_cnt == CW'(BPS_CNT - 1));
  assign is_payload = (byte_idx >= IW'(2)) && (byte_idx < IW'(len) + IW'(2));

`ifdef UART_TX_CRC8_EN
  logic [7:0] crc;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction
`endif

  // The shadow register shifts down one byte per payload load, so payload is always at [7:0].
  always_comb begin
    next_byte = _HEADER;
    if (byte_idx == IW'(1)) next_byte = len;
    else if (is_payload) next_byte = shadow[7:0];
`ifdef UART_TX_CRC8_EN
    else if (byte_idx == IW'(len) + IW'(2)) next_byte = crc;
`endif
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      len         <= '0;
      shadow      <= '0;
      shift       <= '0;
      uart_txd    <= 1'b1;
      bus.tx_busy <= 1'b0;
      bus.tx_done <= 1'b0;
`ifdef UART_TX_CRC8_EN
      crc         <= '0;
`endif
    end else begin
      bus.tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_start && !bus.tx_done) begin
            shadow      <= bus.tx_data;
            len         <= (bus.tx_len > 8'(_MAX_BYTES)) ? 8'(_MAX_BYTES) : bus.tx_len;
            byte_idx    <= '0;
            baud_cnt    <= '0;
            bus.tx_busy <= 1'b1;
`ifdef UART_TX_CRC8_EN
            crc         <= '0;
`endif
            state       <= LOAD;
          end
        end
        LOAD: begin
          shift    <= next_byte;
          if (is_payload) shadow <= shadow >> 8;
`ifdef UART_TX_CRC8_EN
          if (byte_idx == IW'(1) || is_payload) crc <= crc8_step(crc, next_byte);
`endif
          byte_idx <= byte_idx + IW'(1);
          uart_txd <= 1'b0;
          baud_cnt <= '0;
          state    <= START;
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_txd <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx  <= '0;
              uart_txd <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              uart_txd <= shift[1];
              shift    <= {1'b0, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          // With bytes remaining, LOAD itself is the final cycle of the stop bit.
          if (byte_idx < total) begin
            baud_cnt <= baud_cnt + CW'(1);
            if (baud_cnt == CW'(BPS_CNT - 2)) state <= LOAD;
          end else if (baud_end) begin
            baud_cnt    <= '0;
            bus.tx_busy <= 1'b0;
            bus.tx_done <= 1'b1;
            state       <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Scoreboard bench for uart_mult_byte_tx: a line monitor decodes uart_txd and checks bytes
// and start-bit timing against frames predicted from the frame format.
module tb_uart_mult_byte_tx;

  localparam int CLK_FREQ = 1_750_000;
  localparam int BAUD     = 100_000;
  localparam int MAXB     = 11;
  localparam int BPS      = CLK_FREQ / BAUD;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic uart_txd;

  uart_mult_byte_tx_if #(.MAX_BYTES(MAXB)) bus ();

  uart_mult_byte_tx #(
    ._CLK_FREQ (CLK_FREQ),
    ._BAUD     (BAUD),
    ._MAX_BYTES(MAXB),
    ._HEADER   (8'hA5)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus),
    .uart_txd(uart_txd)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   epoch       = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CRC as the remainder of long division of msg * x^8 by x^8 + x^2 + x + 1.
  function automatic logic [7:0] crc8Ref(input logic [7:0] msg[$]);
    logic [8:0] rem;
    logic       bits[$];
    rem = '0;
    foreach (msg[i]) for (int k = 7; k >= 0; k--) bits.push_back(msg[i][k]);
    for (int k = 0; k < 8; k++) bits.push_back(1'b0);
    foreach (bits[i]) begin
      rem = {rem[7:0], bits[i]};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  task automatic applyStimulus(input int len_in, input logic [MAXB*8-1:0] data_in, output int exp_done);
    int         n;
    int         a;
    logic [7:0] body[$];
    logic [7:0] frame[$];
    exp_t       e;
    n = (len_in > MAXB) ? MAXB : len_in;
    body.push_back(8'(n));
    for (int i = 0; i < n; i++) body.push_back(data_in[8*i +: 8]);
    frame.push_back(8'hA5);
    foreach (body[i]) frame.push_back(body[i]);
`ifdef UART_TX_CRC8_EN
    frame.push_back(crc8Ref(body));
`endif
    a = cyc;
    foreach (frame[k]) begin
      e.data  = frame[k];
      e.start = a + 2 + 10 * BPS * k;
      sb.push_back(e);
    end
    exp_done = a + 2 + 10 * BPS * frame.size();
    bus.tx_start = 1'b1;
    bus.tx_len   = 8'(len_in);
    bus.tx_data  = data_in;
    @(negedge sys_clk);
    bus.tx_start = 1'b0;
    checkOutput("busy_after_accept", 32'(bus.tx_busy), 32'd1);
  endtask

  task automatic waitDone(input int exp_done, input bit poke);
    int limit;
    limit = exp_done + 50;
    while (bus.tx_done !== 1'b1 && cyc < limit) @(negedge sys_clk);
    checkOutput("done_cycle", 32'(cyc), 32'(exp_done));
    checkOutput("busy_low_at_done", 32'(bus.tx_busy), 32'd0);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    if (poke) begin
      bus.tx_start = 1'b1;
      bus.tx_len   = 8'd3;
      bus.tx_data  = {MAXB{8'h5A}};
    end
    @(negedge sys_clk);
    bus.tx_start = 1'b0;
    checkOutput("done_one_cycle", 32'(bus.tx_done), 32'd0);
    checkOutput("idle_after_done", 32'(bus.tx_busy), 32'd0);
  endtask

  // Line monitor: detect start edge, sample mid-bit, pop and compare with the scoreboard.
  initial begin
    int         t0;
    int         ep;
    logic [7:0] b;
    logic       stopb;
    exp_t       e;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && uart_txd === 1'b0) begin
        t0 = cyc;
        ep = epoch;
        repeat (BPS / 2) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BPS) @(negedge sys_clk);
          b[i] = uart_txd;
        end
        repeat (BPS) @(negedge sys_clk);
        stopb = uart_txd;
        if (ep == epoch) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_byte", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            checkOutput("line_byte", 32'(b), 32'(e.data));
            checkOutput("start_cycle", 32'(t0), 32'(e.start));
            checkOutput("stop_bit", 32'(stopb), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    int                  ed;
    int                  bad;
    logic [MAXB*8-1:0]   d;
    bus.tx_start = 1'b0;
    bus.tx_len   = '0;
    bus.tx_data  = '0;

    repeat (3) @(negedge sys_clk);
    checkOutput("reset_txd", 32'(uart_txd), 32'd1);
    checkOutput("reset_busy", 32'(bus.tx_busy), 32'd0);
    checkOutput("reset_done", 32'(bus.tx_done), 32'd0);
    sys_rst = 1'b0;

    bad = 0;
    repeat (10000) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) bad++;
    end
    checkOutput("idle_quiet", 32'(bad), 32'd0);

    $display("[TB] fixed frame, payload 01 02");
    d = '0;
    d[15:0] = 16'h0201;
    applyStimulus(2, d, ed);
    waitDone(ed, 1'b0);

    $display("[TB] zero-length frame");
    applyStimulus(0, d, ed);
    waitDone(ed, 1'b0);

    $display("[TB] over-length frame is clamped");
    for (int i = 0; i < MAXB; i++) d[8*i +: 8] = 8'($urandom);
    applyStimulus(20, d, ed);
    waitDone(ed, 1'b0);

    $display("[TB] full-capacity frame");
    for (int i = 0; i < MAXB; i++) d[8*i +: 8] = 8'($urandom);
    applyStimulus(MAXB, d, ed);
    waitDone(ed, 1'b0);

    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < MAXB; i++) d[8*i +: 8] = 8'($urandom);
      applyStimulus(int'($urandom_range(0, 13)), d, ed);
      waitDone(ed, 1'b0);
    end

    $display("[TB] start requests mid-frame and at done are ignored");
    for (int i = 0; i < MAXB; i++) d[8*i +: 8] = 8'($urandom);
    applyStimulus(5, d, ed);
    repeat (25 * BPS) @(negedge sys_clk);
    bus.tx_start = 1'b1;
    bus.tx_len   = 8'd1;
    bus.tx_data  = ~d;
    @(negedge sys_clk);
    bus.tx_start = 1'b0;
    waitDone(ed, 1'b1);
    for (int i = 0; i < MAXB; i++) d[8*i +: 8] = 8'($urandom);
    applyStimulus(3, d, ed);
    waitDone(ed, 1'b0);

    $display("[TB] reset during payload byte");
    for (int i = 0; i < MAXB; i++) d[8*i +: 8] = 8'($urandom);
    applyStimulus(4, d, ed);
    repeat (23 * BPS) @(negedge sys_clk);
    epoch++;
    sb.delete();
    sys_rst = 1'b1;
    #1;
    checkOutput("abort_txd", 32'(uart_txd), 32'd1);
    checkOutput("abort_busy", 32'(bus.tx_busy), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    bad = 0;
    repeat (12 * BPS) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1 || bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b0) bad++;
    end
    checkOutput("quiet_after_abort", 32'(bad), 32'd0);
    for (int i = 0; i < MAXB; i++) d[8*i +: 8] = 8'($urandom);
    applyStimulus(4, d, ed);
    waitDone(ed, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
